// File: rtl/cruise_cmd_conditioner.sv
// Front-end for the cruise control block: turns bouncy driver buttons into clean
// change pulses (with auto-repeat and a both-pressed lockout) and filters alertness.
module cruise_cmd_conditioner #(
  parameter int unsigned DEBOUNCE_CYC  = 4,
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 4,
  parameter int unsigned DROWSY_LEVEL  = 3,
  parameter int unsigned DROWSY_CYC    = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [2:0] alert_raw,
  output logic [1:0] change,
  output logic [2:0] hooshyari,
  output logic       drowsy,
  output logic       lockout
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_e;

  localparam logic [1:0] CHG_HOLD = 2'b00;
  localparam logic [1:0] CHG_UP   = 2'b10;
  localparam logic [1:0] CHG_DOWN = 2'b11;

  localparam logic [7:0] DEB_LIM    = 8'(DEBOUNCE_CYC);
  localparam logic [7:0] RPT_DELAY  = 8'(REPEAT_DELAY);
  localparam logic [7:0] RPT_PERIOD = 8'(REPEAT_PERIOD);
  localparam logic [7:0] DRW_LIM    = 8'(DROWSY_CYC);
  localparam logic [3:0] DRW_LVL    = 4'(DROWSY_LEVEL);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Button vectors: bit 0 is btn_up, bit 1 is btn_down.
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] db_q, db_d, db_prev_q;
  logic [7:0] deb_cnt_q [2];
  logic [7:0] deb_cnt_d [2];

  state_e     state_q, state_d;
  logic       dir_q, dir_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] change_q, change_d;
  logic       lockout_q, lockout_d;

  logic       drowsy_q, drowsy_d;
  logic [7:0] run_q, run_d;
  logic [2:0] hooshyari_q, hooshyari_d;

  logic [1:0] rise;
  logic       pulse;
  logic       pulse_dir;
  logic [1:0] pulse_code;
  logic       below;

  always_comb begin
    // NOTE: every _d gets its default before any branch, so no path can infer a latch.
    db_d = db_q;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = 8'd0;
      if (sync2_q[i] != db_q[i]) begin
        if (sat_inc(deb_cnt_q[i]) >= DEB_LIM) begin
          db_d[i] = ~db_q[i];
        end else begin
          deb_cnt_d[i] = sat_inc(deb_cnt_q[i]);
        end
      end
    end
  end

  assign rise = db_q & ~db_prev_q;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    pulse     = 1'b0;
    pulse_dir = dir_q;
    case (state_q)
      IDLE: begin
        if (&db_q) begin
          state_d = LOCK;
        end else if (rise[0]) begin
          pulse     = 1'b1;
          pulse_dir = 1'b0;
          dir_d     = 1'b0;
          cnt_d     = RPT_DELAY;
          state_d   = HOLD;
        end else if (rise[1]) begin
          pulse     = 1'b1;
          pulse_dir = 1'b1;
          dir_d     = 1'b1;
          cnt_d     = RPT_DELAY;
          state_d   = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (rise[~dir_q]) begin
          state_d = LOCK;
        end else if (!db_q[dir_q]) begin
          state_d = IDLE;
        end else if (cnt_q <= 8'd1) begin
          // The decrement that lands on zero issues the pulse in the same cycle.
          pulse   = 1'b1;
          cnt_d   = RPT_PERIOD;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      LOCK: begin
        if (db_q == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pulse_code = pulse_dir ? CHG_DOWN : CHG_UP;

  always_comb begin
    change_d = CHG_HOLD;
    if (pulse && !drowsy_d && (change_q != pulse_code)) change_d = pulse_code;
    lockout_d = (state_d == LOCK);
  end

  assign below = ({1'b0, alert_raw} < DRW_LVL);

  always_comb begin
    drowsy_d = drowsy_q;
    run_d    = 8'd0;
    if (below != drowsy_q) begin
      if (sat_inc(run_q) >= DRW_LIM) begin
        drowsy_d = ~drowsy_q;
      end else begin
        run_d = sat_inc(run_q);
      end
    end
    hooshyari_d = drowsy_d ? 3'b000 : alert_raw;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      db_q        <= 2'b00;
      db_prev_q   <= 2'b00;
      // NOTE: the counter array is ordinary flops, so it is cleared with the rest.
      deb_cnt_q   <= '{8'd0, 8'd0};
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      cnt_q       <= 8'd0;
      change_q    <= CHG_HOLD;
      lockout_q   <= 1'b0;
      drowsy_q    <= 1'b0;
      run_q       <= 8'd0;
      hooshyari_q <= 3'b111;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values together.
      sync1_q     <= {btn_down, btn_up};
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      db_prev_q   <= db_q;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      change_q    <= change_d;
      lockout_q   <= lockout_d;
      drowsy_q    <= drowsy_d;
      run_q       <= run_d;
      hooshyari_q <= hooshyari_d;
    end
  end

  assign change    = change_q;
  assign hooshyari = hooshyari_q;
  assign drowsy    = drowsy_q;
  assign lockout   = lockout_q;

  a_no_code_01: assert property (@(posedge clock) disable iff (!reset_n)
    change != 2'b01);
  a_no_repeat_code: assert property (@(posedge clock) disable iff (!reset_n)
    (change != CHG_HOLD) |=> (change != $past(change)));
  a_lock_quiet: assert property (@(posedge clock) disable iff (!reset_n)
    lockout |-> (change == CHG_HOLD));
  a_drowsy_quiet: assert property (@(posedge clock) disable iff (!reset_n)
    drowsy |-> (change == CHG_HOLD && hooshyari == 3'b000));

endmodule
